// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl (master) and the IR/ALU/NPC datapath plus
// unified memory port (slave).
interface mc_ctrl_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               mem_ready;
  logic               IRWrite;
  logic               PCWrite;
  logic [1:0]         NPCOp;
  logic               MemRead;
  logic               MemWrite;
  logic               IorD;
  logic               MDRWrite;
  logic               RegWrite;
  logic [1:0]         GPRSel;
  logic [1:0]         WDSel;
  logic               EXTOp;
  logic               ALUSrc;
  logic [ALUOP_W-1:0] ALUOp;

  // Memory handshake: MemRead/MemWrite is held high until the memory raises
  // mem_ready; the access completes in that cycle. mem_ready with no request
  // up carries no meaning and is ignored.
  modport master (
    input  Op, Funct, Zero, mem_ready,
    output IRWrite, PCWrite, NPCOp, MemRead, MemWrite, IorD, MDRWrite,
           RegWrite, GPRSel, WDSel, EXTOp, ALUSrc, ALUOp
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  IRWrite, PCWrite, NPCOp, MemRead, MemWrite, IorD, MDRWrite,
           RegWrite, GPRSel, WDSel, EXTOp, ALUSrc, ALUOp
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with illegal-opcode
// and bus-timeout trapping and a retired-instruction counter.
module mc_ctrl #(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_if.master        bus,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_RALU, K_IMM, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR
  } kind_t;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(8);

  localparam logic [1:0] NPC_SEQ = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;
  localparam logic [1:0] GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_R31 = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MDR = 2'b01, WD_PC4 = 2'b10;
  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILL = 2'b01, CAUSE_BUS = 2'b10;

  state_t             state_q, state_d;
  logic [7:0]         wait_q, wait_inc;
  logic               timeout;
  logic [1:0]         trap_cause;
  kind_t              kind;
  logic [ALUOP_W-1:0] dec_alu;
  logic               dec_src, dec_ext;

  logic               ir_write, pc_write, mem_read, mem_write, iord, mdr_write, reg_write;
  logic               ext_op, alu_src;
  logic [1:0]         npc_op, gpr_sel, wd_sel;
  logic [ALUOP_W-1:0] alu_op;

  // Instruction class and its EXEC-stage ALU controls.
  always_comb begin
    kind    = K_ILL;
    dec_alu = ALU_NOP;
    dec_src = 1'b0;
    dec_ext = 1'b0;
    case (bus.Op)
      6'h00: begin
        case (bus.Funct)
          6'h20, 6'h21: begin kind = K_RALU; dec_alu = ALU_ADD;  end
          6'h22, 6'h23: begin kind = K_RALU; dec_alu = ALU_SUB;  end
          6'h24:        begin kind = K_RALU; dec_alu = ALU_AND;  end
          6'h25:        begin kind = K_RALU; dec_alu = ALU_OR;   end
          6'h27:        begin kind = K_RALU; dec_alu = ALU_NOR;  end
          6'h2a:        begin kind = K_RALU; dec_alu = ALU_SLT;  end
          6'h2b:        begin kind = K_RALU; dec_alu = ALU_SLTU; end
          6'h08:        kind = K_JR;
          6'h09:        kind = K_JALR;
          default:      kind = K_ILL;
        endcase
      end
      6'h08: begin kind = K_IMM; dec_alu = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h0d: begin kind = K_IMM; dec_alu = ALU_OR;  dec_src = 1'b1; end
      6'h0c: begin kind = K_IMM; dec_alu = ALU_AND; dec_src = 1'b1; end
      6'h23: begin kind = K_LW;  dec_alu = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h2b: begin kind = K_SW;  dec_alu = ALU_ADD; dec_src = 1'b1; dec_ext = 1'b1; end
      6'h04: begin kind = K_BEQ; dec_alu = ALU_SUB; end
      6'h05: begin kind = K_BNE; dec_alu = ALU_SUB; end
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      default: kind = K_ILL;
    endcase
  end

  assign wait_inc = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
  assign timeout  = (wait_inc == 8'(WAIT_MAX));

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    npc_op     = NPC_SEQ;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mdr_write  = 1'b0;
    reg_write  = 1'b0;
    gpr_sel    = GPR_RD;
    wd_sel     = WD_ALU;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_NOP;
    state_d    = state_q;
    trap_cause = CAUSE_NONE;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d    = S_TRAP;
          trap_cause = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        case (kind)
          K_ILL: begin
            state_d    = S_TRAP;
            trap_cause = CAUSE_ILL;
          end
          K_J: begin
            pc_write = 1'b1;
            npc_op   = NPC_JUMP;
            state_d  = S_FETCH;
          end
          K_JAL: begin
            pc_write  = 1'b1;
            npc_op    = NPC_JUMP;
            reg_write = 1'b1;
            gpr_sel   = GPR_R31;
            wd_sel    = WD_PC4;
            state_d   = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_op  = dec_alu;
        alu_src = dec_src;
        ext_op  = dec_ext;
        case (kind)
          K_BEQ, K_BNE: begin
            pc_write = 1'b1;
            if ((kind == K_BEQ && bus.Zero) || (kind == K_BNE && !bus.Zero)) npc_op = NPC_BRANCH;
            state_d  = S_FETCH;
          end
          K_JR, K_JALR: begin
            pc_write = 1'b1;
            npc_op   = NPC_JR;
            if (kind == K_JALR) begin
              reg_write = 1'b1;
              wd_sel    = WD_PC4;
            end
            state_d  = S_FETCH;
          end
          K_LW, K_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        iord      = 1'b1;
        alu_op    = ALU_ADD;
        mem_read  = (kind == K_LW);
        mem_write = (kind == K_SW);
        if (bus.mem_ready) begin
          if (kind == K_LW) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (timeout) begin
          state_d    = S_TRAP;
          trap_cause = CAUSE_BUS;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (kind == K_LW) begin
          wd_sel  = WD_MDR;
          gpr_sel = GPR_RT;
        end else if (kind == K_IMM) begin
          gpr_sel = GPR_RT;
        end
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Nothing may reach the datapath while reset is being applied.
    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      npc_op    = NPC_SEQ;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      mdr_write = 1'b0;
      reg_write = 1'b0;
      gpr_sel   = GPR_RD;
      wd_sel    = WD_ALU;
      ext_op    = 1'b0;
      alu_src   = 1'b0;
      alu_op    = ALU_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      trap    <= 1'b0;
      cause   <= CAUSE_NONE;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || bus.mem_ready) wait_q <= 8'd0;
      else if (state_q == S_FETCH || state_q == S_MEM) wait_q <= wait_inc;
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap  <= 1'b1;
        cause <= trap_cause;
      end
      if (pc_write) instret <= instret + CNT_W'(1);
    end
  end

  assign state        = state_q;
  assign bus.IRWrite  = ir_write;
  assign bus.PCWrite  = pc_write;
  assign bus.NPCOp    = npc_op;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IorD     = iord;
  assign bus.MDRWrite = mdr_write;
  assign bus.RegWrite = reg_write;
  assign bus.GPRSel   = gpr_sel;
  assign bus.WDSel    = wd_sel;
  assign bus.EXTOp    = ext_op;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = alu_op;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: instruction-level reference model feeds an expected queue
// of per-cycle control words; a negedge monitor pops and compares.
module tb_mc_ctrl;

  localparam int W_MAX = 4;
  localparam int W     = 58;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
  localparam logic [1:0] C_ILL = 2'b01, C_BUS = 2'b10;

  localparam int K_ILL = 0, K_R = 1, K_IMM = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_JALR = 10;

  typedef struct packed {
    logic       ir;
    logic       pcw;
    logic [1:0] npc;
    logic       mr;
    logic       mw;
    logic       iord;
    logic       mdr;
    logic       rw;
    logic [1:0] gsel;
    logic [1:0] wsel;
    logic       ext;
    logic       src;
    logic [3:0] alu;
  } ctrl_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  cause;
  logic [31:0] instret;

  mc_ctrl_if #(.ALUOP_W(4)) bus ();

  mc_ctrl #(.ALUOP_W(4), .WAIT_MAX(W_MAX), .CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state   (state),
    .trap    (trap),
    .cause   (cause),
    .instret (instret)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [2:0]   m_state;
  logic         m_trap;
  logic [1:0]   m_cause;
  logic [31:0]  m_instret;
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void classify(input logic [5:0] op, input logic [5:0] funct,
                                   output int k, output logic [3:0] alu,
                                   output logic src, output logic ext);
    k = K_ILL; alu = 4'd0; src = 1'b0; ext = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h21: begin k = K_R; alu = 4'd1; end
        6'h22, 6'h23: begin k = K_R; alu = 4'd2; end
        6'h24: begin k = K_R; alu = 4'd3; end
        6'h25: begin k = K_R; alu = 4'd4; end
        6'h27: begin k = K_R; alu = 4'd8; end
        6'h2a: begin k = K_R; alu = 4'd5; end
        6'h2b: begin k = K_R; alu = 4'd6; end
        6'h08: k = K_JR;
        6'h09: k = K_JALR;
        default: k = K_ILL;
      endcase
    end else begin
      case (op)
        6'h08: begin k = K_IMM; alu = 4'd1; src = 1'b1; ext = 1'b1; end
        6'h0d: begin k = K_IMM; alu = 4'd4; src = 1'b1; end
        6'h0c: begin k = K_IMM; alu = 4'd3; src = 1'b1; end
        6'h23: begin k = K_LW;  alu = 4'd1; src = 1'b1; ext = 1'b1; end
        6'h2b: begin k = K_SW;  alu = 4'd1; src = 1'b1; ext = 1'b1; end
        6'h04: begin k = K_BEQ; alu = 4'd2; end
        6'h05: begin k = K_BNE; alu = 4'd2; end
        6'h02: k = K_J;
        6'h03: k = K_JAL;
        default: k = K_ILL;
      endcase
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input ctrl_t c, input logic rdy, input logic [2:0] nxt, input logic [1:0] tc);
    bus.mem_ready = rdy;
    exp_q.push_back({c, m_state, m_trap, m_cause, m_instret});
    @(posedge clk);
    #1;
    if (c.pcw) m_instret = m_instret + 32'd1;
    if (nxt == S_TRAP && m_state != S_TRAP) begin
      m_trap  = 1'b1;
      m_cause = tc;
    end
    m_state = nxt;
  endtask

  task automatic do_reset();
    ctrl_t c;
    c = '0;
    rst = 1'b1;
    bus.mem_ready = coin();
    exp_q.push_back({c, m_state, m_trap, m_cause, m_instret});
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = S_FETCH; m_trap = 1'b0; m_cause = 2'b00; m_instret = 32'd0;
  endtask

  task automatic trap_hold(input int n);
    ctrl_t c;
    c = '0;
    for (int i = 0; i < n; i++) begin
      bus.Op    = 6'($urandom_range(0, 63));
      bus.Funct = 6'($urandom_range(0, 63));
      step(c, coin(), S_TRAP, 2'b00);
    end
  endtask

  // fd/md: index of the wait cycle in which mem_ready arrives (>= W_MAX times out);
  // rim: MEM cycle in which reset is applied instead (-1 for none).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                           input int fd, input int md, input int rim, output logic trapped);
    int k;
    logic [3:0] alu;
    logic src, ext;
    ctrl_t c;
    trapped = 1'b0;
    classify(op, funct, k, alu, src, ext);
    bus.Op = op; bus.Funct = funct; bus.Zero = z;
    for (int i = 0; i < W_MAX; i++) begin
      c = '0; c.mr = 1'b1;
      if (i == fd) begin
        c.ir = 1'b1;
        step(c, 1'b1, S_DECODE, 2'b00);
        break;
      end
      if (i + 1 == W_MAX) begin
        step(c, 1'b0, S_TRAP, C_BUS);
        trapped = 1'b1;
        return;
      end
      step(c, 1'b0, S_FETCH, 2'b00);
    end
    c = '0;
    if (k == K_ILL) begin
      step(c, coin(), S_TRAP, C_ILL);
      trapped = 1'b1;
      return;
    end
    if (k == K_J || k == K_JAL) begin
      c.pcw = 1'b1; c.npc = 2'b10;
      if (k == K_JAL) begin c.rw = 1'b1; c.gsel = 2'b10; c.wsel = 2'b10; end
      step(c, coin(), S_FETCH, 2'b00);
      return;
    end
    step(c, coin(), S_EXEC, 2'b00);
    c = '0; c.alu = alu; c.src = src; c.ext = ext;
    if (k == K_BEQ || k == K_BNE) begin
      c.pcw = 1'b1;
      c.npc = ((k == K_BEQ && z) || (k == K_BNE && !z)) ? 2'b01 : 2'b00;
      step(c, coin(), S_FETCH, 2'b00);
      return;
    end
    if (k == K_JR || k == K_JALR) begin
      c.pcw = 1'b1; c.npc = 2'b11;
      if (k == K_JALR) begin c.rw = 1'b1; c.wsel = 2'b10; end
      step(c, coin(), S_FETCH, 2'b00);
      return;
    end
    if (k == K_LW || k == K_SW) begin
      step(c, coin(), S_MEM, 2'b00);
      for (int i = 0; i < W_MAX; i++) begin
        c = '0; c.iord = 1'b1; c.alu = 4'd1;
        c.mr = (k == K_LW); c.mw = (k == K_SW);
        if (i == rim) begin
          do_reset();
          return;
        end
        if (i == md) begin
          if (k == K_LW) begin
            c.mdr = 1'b1;
            step(c, 1'b1, S_WB, 2'b00);
            break;
          end
          c.pcw = 1'b1;
          step(c, 1'b1, S_FETCH, 2'b00);
          return;
        end
        if (i + 1 == W_MAX) begin
          step(c, 1'b0, S_TRAP, C_BUS);
          trapped = 1'b1;
          return;
        end
        step(c, 1'b0, S_MEM, 2'b00);
      end
    end else begin
      step(c, coin(), S_WB, 2'b00);
    end
    c = '0; c.rw = 1'b1; c.pcw = 1'b1;
    if (k == K_LW) begin c.wsel = 2'b01; c.gsel = 2'b01; end
    else if (k == K_IMM) c.gsel = 2'b01;
    step(c, coin(), S_FETCH, 2'b00);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    cyc++;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      act = {bus.IRWrite, bus.PCWrite, bus.NPCOp, bus.MemRead, bus.MemWrite, bus.IorD,
             bus.MDRWrite, bus.RegWrite, bus.GPRSel, bus.WDSel, bus.EXTOp, bus.ALUSrc,
             bus.ALUOp, state, trap, cause, instret};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL ctrl cyc=%0d state=%0d got=%h want=%h", cyc, state, act, exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] r_funct[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h2b, 6'h08, 6'h09};
  logic [5:0] i_op[9]     = '{6'h08, 6'h0d, 6'h0c, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

  initial begin
    logic tr;
    logic [5:0] op, fn;
    int fd, md;
    bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = S_FETCH; m_trap = 1'b0; m_cause = 2'b00; m_instret = 32'd0;

    run_instr(6'h00, 6'h21, 1'b0, 0, 0, -1, tr);   // addu
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, -1, tr);   // lw, ready late in MEM
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1, tr);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1, tr);   // beq not taken
    run_instr(6'h05, 6'h00, 1'b0, 1, 0, -1, tr);   // bne taken
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, -1, tr);   // jal
    run_instr(6'h00, 6'h09, 1'b0, 2, 0, -1, tr);   // jalr
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1, tr);   // illegal opcode
    trap_hold(20);
    do_reset();
    run_instr(6'h00, 6'h3F, 1'b0, 0, 0, -1, tr);   // illegal funct
    trap_hold(3);
    do_reset();
    run_instr(6'h00, 6'h21, 1'b0, W_MAX, 0, -1, tr); // fetch timeout
    trap_hold(5);
    do_reset();
    run_instr(6'h00, 6'h21, 1'b0, W_MAX - 1, 0, -1, tr); // ready on last allowed cycle
    run_instr(6'h2b, 6'h00, 1'b0, 1, W_MAX - 1, -1, tr); // sw
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1, tr);    // reset mid-access
    run_instr(6'h2b, 6'h00, 1'b0, 0, W_MAX, -1, tr); // mem timeout
    trap_hold(2);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
        1, 2, 3, 4: begin op = 6'h00; fn = r_funct[$urandom_range(0, 10)]; end
        default: begin op = i_op[$urandom_range(0, 8)]; fn = 6'($urandom_range(0, 63)); end
      endcase
      fd = ($urandom_range(0, 14) == 0) ? W_MAX : $urandom_range(0, W_MAX - 1);
      md = ($urandom_range(0, 14) == 0) ? W_MAX : $urandom_range(0, W_MAX - 1);
      run_instr(op, fn, coin(), fd, md, -1, tr);
      if (tr) begin
        trap_hold($urandom_range(1, 6));
        do_reset();
      end
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
